instr_feeder: RTL and testbench

//  Upstream stage of the cpu: buffers 16-bit instructions written by a host
//  (switch/test harness) in a small FIFO and issues them one at a time over
//  the cpu's in/load/s/w handshake. It waits for the cpu to return to wait
//  (w=1) before issuing the next instruction. It counts retired instructions
//  and flags overflow and stall errors.

---
 rtl/feeder_pkg.sv | 15 +
 rtl/instr_fifo.sv | 55 +++++
 rtl/instr_feeder.sv | 121 ++++++++++++
 tb/tb_instr_feeder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types for the instruction feeder: FSM state encoding and the
// width of the START/EXEC watchdog timer.
package feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        EXEC,
        ERR
    } state_t;

    localparam int TMR_W = 16;

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO: DEPTH x WIDTH circular buffer with occupancy count.
// Ports: clk, reset (async active-low), wr_en/wr_data, rd_en/rd_data
// (rd_data shows the head), full, empty, count.
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_feeder.sv
// Issues queued instructions to the cpu over the in/load/s/w handshake.
// Ports: host side wr_en/wr_data/run/clr_err; cpu side cpu_in, cpu_load,
// cpu_s, cpu_w; status full/empty/count/busy/retired/overflow/stall.
module instr_feeder #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             run,
    input  logic             clr_err,
    input  logic             cpu_w,
    output logic [WIDTH-1:0] cpu_in,
    output logic             cpu_load,
    output logic             cpu_s,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic [7:0]       retired,
    output logic             overflow,
    output logic             stall
);

    import feeder_pkg::*;

    localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [WIDTH-1:0] head;
    logic             go;
    logic             drop;
    logic             tmo_hit;

    assign go      = (state == IDLE) && run && !empty && cpu_w && !stall;
    assign drop    = wr_en && full && !go;
    assign busy    = (state != IDLE);
    // Timer is zero in the first START cycle, so this fires on cycle TIMEOUT.
    assign tmo_hit = ((timer + 1'b1) == TMO);

    instr_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .rd_en  (go),
        .rd_data(head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            timer    <= '0;
            cpu_in   <= '0;
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            retired  <= '0;
            overflow <= 1'b0;
            stall    <= 1'b0;
        end else begin
            cpu_load <= 1'b0;
            overflow <= !clr_err && (overflow || drop);
            if (clr_err) stall <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        cpu_in   <= head;
                        cpu_load <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    cpu_s <= 1'b1;
                    timer <= '0;
                    state <= START;
                end
                START: begin
                    if (!cpu_w) begin
                        cpu_s <= 1'b0;
                        timer <= timer + 1'b1;
                        state <= EXEC;
                    end else if (tmo_hit) begin
                        cpu_s <= 1'b0;
                        state <= ERR;
                        if (!clr_err) stall <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                EXEC: begin
                    if (cpu_w) begin
                        retired <= retired + 8'd1;
                        state   <= IDLE;
                    end else if (tmo_hit) begin
                        state <= ERR;
                        if (!clr_err) stall <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ERR: begin
                    cpu_s <= 1'b0;
                    if (clr_err) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// Scoreboard bench for instr_feeder: queued instructions are checked
// against each cpu_load pulse by an independent monitor.
module tb_instr_feeder;

    localparam int DEPTH   = 8;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             run;
    logic             clr_err;
    logic             cpu_w;
    logic [WIDTH-1:0] cpu_in;
    logic             cpu_load;
    logic             cpu_s;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             busy;
    logic [7:0]       retired;
    logic             overflow;
    logic             stall;

    int checks = 0;
    int errors = 0;
    int loads  = 0;
    bit hold_w = 1'b0;
    logic [WIDTH-1:0] sb [$];

    instr_feeder #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .run     (run),
        .clr_err (clr_err),
        .cpu_w   (cpu_w),
        .cpu_in  (cpu_in),
        .cpu_load(cpu_load),
        .cpu_s   (cpu_s),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .busy    (busy),
        .retired (retired),
        .overflow(overflow),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // cpu model: drops w for 5 cycles once it sees a start request
    initial begin
        cpu_w = 1'b1;
        forever begin
            @(negedge clk);
            if (reset && cpu_s && !hold_w) begin
                cpu_w = 1'b0;
                repeat (5) @(negedge clk);
                cpu_w = 1'b1;
            end
        end
    end

    // monitor: every load pulse must match the scoreboard head
    always @(negedge clk) begin
        if (reset && cpu_load) begin
            loads++;
            if (sb.size() == 0) begin
                chk("unexpected_load", cpu_in, 32'hFFFF_FFFF);
            end else begin
                chk("cpu_in", cpu_in, sb.pop_front());
            end
        end
    end

    task automatic wr(input logic [WIDTH-1:0] d, input bit exp_ok);
        wr_en   = 1'b1;
        wr_data = d;
        if (exp_ok) sb.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_ret(input logic [7:0] n);
        int k = 0;
        while (retired != n && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("retired", retired, n);
    endtask

    task automatic wait_s();
        int k = 0;
        while (!cpu_s && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("s_seen", cpu_s, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cpu_in", cpu_in, 0);
        chk("rst_load", cpu_load, 0);
        chk("rst_s", cpu_s, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_retired", retired, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_stall", stall, 0);
    endtask

    initial begin
        int k;
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        run     = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b1;

        // 1: three instructions through the handshake
        wr(16'hD105, 1);
        wr(16'hD203, 1);
        wr(16'hA0A1, 1);
        chk("t1_count", count, 3);
        run = 1'b1;
        wait_ret(8'd3);
        chk("t1_empty", empty, 1);
        chk("t1_hold", cpu_in, 16'hA0A1);

        // 2: overfill with run low
        run = 1'b0;
        for (int i = 0; i <= DEPTH; i++)
            wr(WIDTH'(16'h1000 + i), i < DEPTH);
        chk("t2_full", full, 1);
        chk("t2_count", count, DEPTH);
        chk("t2_ovf", overflow, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t2_clr", overflow, 0);

        // 3: write coincides with pop while full
        run = 1'b1;
        wr(16'h2000, 1);
        chk("t3_count", count, DEPTH);
        chk("t3_full", full, 1);
        chk("t3_ovf", overflow, 0);
        wait_ret(8'd12);
        chk("t3_empty", empty, 1);

        // 4: cpu never leaves wait -> stall
        hold_w = 1'b1;
        wr(16'h3333, 1);
        wait_s();
        k = 0;
        while (cpu_s && k < 200) begin
            k++;
            @(negedge clk);
        end
        chk("t4_cycles", k, TIMEOUT);
        chk("t4_stall", stall, 1);
        chk("t4_busy", busy, 1);
        chk("t4_s", cpu_s, 0);
        chk("t4_ret", retired, 12);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t4_clr", stall, 0);
        chk("t4_idle", busy, 0);

        // 5: drop run during EXEC
        run    = 1'b0;
        hold_w = 1'b0;
        wr(16'h4441, 1);
        wr(16'h4442, 0);
        run = 1'b1;
        k   = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(busy && !cpu_s && !cpu_load) && k < 50);
        chk("t5_exec", busy, 1);
        run = 1'b0;
        wait_ret(8'd13);
        repeat (20) @(negedge clk);
        chk("t5_ret", retired, 13);
        chk("t5_count", count, 1);
        chk("t5_busy", busy, 0);

        // 6: reset during START with 4 queued
        hold_w = 1'b1;
        sb.push_back(16'h4442);
        for (int i = 1; i <= 4; i++)
            wr(WIDTH'(16'h5550 + i), 0);
        chk("t6_count5", count, 5);
        run = 1'b1;
        wait_s();
        chk("t6_count4", count, 4);
        reset = 1'b0;
        #1;
        chk_reset_vals();
        run = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        hold_w = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("loads", loads, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
